// File: rtl/sm3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_pkg
//  Description : Shared constants and the padder state type for the SM3
//                message padder (block width, length-field width, pad byte).
//  Revision    : 1.0  initial release
// ============================================================================
package sm3_pkg;

  localparam int         SM3_BLK_W    = 512;
  localparam int         SM3_LEN_W    = 64;
  localparam logic [7:0] SM3_PAD_BYTE = 8'h80;

  // FILL      : collecting message words into the block buffer
  // EMIT      : presenting a non-final block
  // LENBLK    : building the trailing length-only block
  // EMIT_LAST : presenting the final block of the message
  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_EMIT      = 2'd1,
    ST_LENBLK    = 2'd2,
    ST_EMIT_LAST = 2'd3
  } sm3_state_e;

endpackage
`default_nettype wire

// File: rtl/sm3_pad_mask.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_pad_mask
//  Description : Combinational helper. From the word slot index and the
//                valid-byte count of the incoming word, produces the byte
//                keep-mask for that word and the byte position in the block
//                where the 0x80 pad byte belongs.
//  Ports       : widx       - word slot the word is written to
//                in_bytes   - valid bytes on a last word (0 = all)
//                in_last    - word is the final word of the message
//                keep       - per-byte keep mask, MSB bit = first byte
//                pad_pos    - block byte index of the pad byte (0..64)
//                pad_in_blk - pad byte lands inside the current block
//                fits       - pad byte leaves room for the 8-byte length
//  Revision    : 1.0  initial release
// ============================================================================
module sm3_pad_mask #(
  parameter int WORD_W = 32
) (
  input  logic [$clog2(512/WORD_W)-1:0] widx,
  input  logic [$clog2(WORD_W/8)-1:0]   in_bytes,
  input  logic                          in_last,
  output logic [WORD_W/8-1:0]           keep,
  output logic [6:0]                    pad_pos,
  output logic                          pad_in_blk,
  output logic                          fits
);

  localparam int BPW = WORD_W / 8;

  // Number of message bytes this word contributes; in_bytes only matters
  // on the final word.
  logic [3:0] w_nb;
  assign w_nb = (!in_last || in_bytes == '0) ? 4'(BPW) : 4'(in_bytes);

  // The pad byte sits right after the last message byte of the block.
  assign pad_pos    = 7'(widx) * 7'(BPW) + 7'(w_nb);
  assign pad_in_blk = pad_pos < 7'd64;
  // Message plus pad byte must end at or before byte 56 to leave room for
  // the length field in the same block.
  assign fits       = pad_pos <= 7'd55;

  generate
    for (genvar i = 0; i < BPW; i++) begin : g_keep
      assign keep[BPW-1-i] = 4'(i) < w_nb;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sm3_stream_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sm3_stream_padder
//  Description : Streams big-endian message words into 512-bit SM3 blocks,
//                appending the 0x80 pad byte, zero fill and the 64-bit
//                message bit length, with valid/ready on both sides.
//  Ports       : clk, rst (async, active-low)
//                in_valid/in_ready/in_data/in_last/in_bytes - word input
//                blk_valid/blk_ready/blk_data/blk_last      - block output
//                busy - message in progress or block pending
//  Revision    : 1.0  initial release
// ============================================================================
module sm3_stream_padder
  import sm3_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  input  logic [$clog2(WORD_W/8)-1:0] in_bytes,
  output logic                        blk_valid,
  input  logic                        blk_ready,
  output logic [SM3_BLK_W-1:0]        blk_data,
  output logic                        blk_last,
  output logic                        busy
);

  localparam int WPB    = SM3_BLK_W / WORD_W;
  localparam int BPW    = WORD_W / 8;
  localparam int WIDX_W = $clog2(WPB);

  localparam logic [SM3_BLK_W-1:0] c_PAD_TOP = {SM3_PAD_BYTE, {(SM3_BLK_W-8){1'b0}}};

  sm3_state_e            r_state, w_state_nxt;
  logic [WIDX_W-1:0]     r_widx;
  logic [LEN_W-1:0]      r_cnt;
  logic [SM3_BLK_W-1:0]  r_buf;
  logic                  r_need_len;  // final word did not leave room for length
  logic                  r_pad_next;  // pad byte spills into the length block
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_slot_full;
  logic [LEN_W-1:0]      w_add;
  logic [LEN_W-1:0]      w_cnt_nxt;
  logic [BPW-1:0]        w_keep;
  logic [6:0]            w_pad_pos;
  logic                  w_pad_in_blk;
  logic                  w_fits;
  logic [WORD_W-1:0]     w_word_masked;
  logic [SM3_BLK_W-1:0]  w_word_blk;
  logic [SM3_BLK_W-1:0]  w_pad_blk;
  logic [SM3_LEN_W-1:0]  w_len_cur;
  logic [SM3_LEN_W-1:0]  w_len_reg;
  logic [SM3_BLK_W-1:0]  w_len_cur_blk;
  logic [SM3_BLK_W-1:0]  w_len_reg_blk;

  sm3_pad_mask #(.WORD_W(WORD_W)) u_pad_mask (
    .widx       (r_widx),
    .in_bytes   (in_bytes),
    .in_last    (in_last),
    .keep       (w_keep),
    .pad_pos    (w_pad_pos),
    .pad_in_blk (w_pad_in_blk),
    .fits       (w_fits)
  );

  assign w_accept    = in_valid & in_ready;
  assign w_slot_full = r_widx == WIDX_W'(WPB - 1);

  assign w_add     = (in_last && in_bytes != '0) ? LEN_W'({in_bytes, 3'b000}) : LEN_W'(WORD_W);
  assign w_cnt_nxt = r_cnt + w_add;   // wraps modulo 2^LEN_W

  // Bytes past the valid count are dropped so the zero fill stays clean.
  generate
    for (genvar j = 0; j < BPW; j++) begin : g_mask
      assign w_word_masked[8*j +: 8] = w_keep[j] ? in_data[8*j +: 8] : 8'h00;
    end
  endgenerate

  assign w_word_blk = {w_word_masked, {(SM3_BLK_W-WORD_W){1'b0}}} >> (10'(r_widx) * 10'(WORD_W));
  assign w_pad_blk  = w_pad_in_blk ? (c_PAD_TOP >> {w_pad_pos, 3'b000}) : '0;

  // Length field: the count including the word being accepted, or the
  // already-final count when building the separate length block.
  assign w_len_cur     = SM3_LEN_W'(w_cnt_nxt);
  assign w_len_reg     = SM3_LEN_W'(r_cnt);
  assign w_len_cur_blk = {{(SM3_BLK_W-SM3_LEN_W){1'b0}}, w_len_cur};
  assign w_len_reg_blk = {{(SM3_BLK_W-SM3_LEN_W){1'b0}}, w_len_reg};

  // The block buffer is the output register: it is complete one cycle after
  // the word that finishes it and is held untouched while in an EMIT state.
  assign blk_data = r_buf;
  assign busy     = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_FILL;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    blk_valid   = 1'b0;
    blk_last    = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (in_last)          w_state_nxt = w_fits ? ST_EMIT_LAST : ST_EMIT;
          else if (w_slot_full) w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        blk_valid = 1'b1;
        if (blk_ready) w_state_nxt = r_need_len ? ST_LENBLK : ST_FILL;
      end
      ST_LENBLK: begin
        w_state_nxt = ST_EMIT_LAST;
      end
      ST_EMIT_LAST: begin
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        if (blk_ready) w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_widx     <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_need_len <= 1'b0;
      r_pad_next <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_widx <= r_widx + WIDX_W'(1);
            if (in_last) begin
              r_buf      <= r_buf | w_word_blk | w_pad_blk | (w_fits ? w_len_cur_blk : '0);
              r_need_len <= !w_fits;
              r_pad_next <= !w_pad_in_blk;
            end else begin
              r_buf      <= r_buf | w_word_blk;
              r_need_len <= 1'b0;
              r_pad_next <= 1'b0;
            end
          end
        end
        ST_EMIT: begin
          if (blk_ready) begin
            r_buf  <= '0;
            r_widx <= '0;
          end
        end
        ST_LENBLK: begin
          r_buf <= w_len_reg_blk | (r_pad_next ? c_PAD_TOP : '0);
        end
        ST_EMIT_LAST: begin
          if (blk_ready) begin
            r_buf      <= '0;
            r_widx     <= '0;
            r_cnt      <= '0;
            r_need_len <= 1'b0;
            r_pad_next <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm3_stream_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm3_stream_padder
//  Description : Self-checking bench for sm3_stream_padder (32- and 64-bit
//                word instances) against a byte-level SM3 padding model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm3_stream_padder;

  localparam logic [511:0] c_ABC = {32'h61626380, 416'h0, 64'h18};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        v32, r32, l32, bv32, brdy32, bl32, busy32;
  logic [31:0] d32;
  logic [1:0]  b32;
  logic [511:0] bd32;

  logic        v64, r64, l64, bv64, brdy64, bl64, busy64;
  logic [63:0] d64;
  logic [2:0]  b64;
  logic [511:0] bd64;

  sm3_stream_padder #(.WORD_W(32), .LEN_W(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_data(d32),
    .in_last(l32), .in_bytes(b32), .blk_valid(bv32), .blk_ready(brdy32),
    .blk_data(bd32), .blk_last(bl32), .busy(busy32)
  );

  sm3_stream_padder #(.WORD_W(64), .LEN_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_data(d64),
    .in_last(l64), .in_bytes(b64), .blk_valid(bv64), .blk_ready(brdy64),
    .blk_data(bd64), .blk_last(bl64), .busy(busy64)
  );

  int checks   = 0;
  int failures = 0;
  bit rnd_rdy  = 1'b0;

  logic [511:0] q_d32[$], q_d64[$];
  bit           q_l32[$], q_l64[$];
  logic [511:0] e_d[$];
  bit           e_l[$];
  logic [7:0]   msg[$];

  // A block counts as delivered when valid & ready are seen mid-cycle;
  // the handshake then completes on the next rising edge.
  always @(negedge clk) begin
    if (rst && bv32 && brdy32) begin q_d32.push_back(bd32); q_l32.push_back(bl32); end
    if (rst && bv64 && brdy64) begin q_d64.push_back(bd64); q_l64.push_back(bl64); end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      brdy32 = 1'($urandom_range(0, 1));
      brdy64 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic put_word(input bit w64, input logic [63:0] data, input bit last, input logic [2:0] nb);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (w64) begin v64 = 1'b1; d64 = data; l64 = last; b64 = nb; end
    else     begin v32 = 1'b1; d32 = data[31:0]; l32 = last; b32 = nb[1:0]; end
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = w64 ? r64 : r32;
      tick();
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL put_word timeout: in_ready=0 required 1");
    end
    if (w64) v64 = 1'b0; else v32 = 1'b0;
  endtask

  // Bytes past the message end on the last word, and in_bytes on
  // non-last words, are random: the DUT must ignore them.
  task automatic send_msg(input bit w64);
    int bpw, n, nw, k;
    logic [63:0] d;
    logic [7:0]  b;
    logic [2:0]  nb;
    bit          last;
    bpw = w64 ? 8 : 4;
    n   = msg.size();
    nw  = (n + bpw - 1) / bpw;
    for (int i = 0; i < nw; i++) begin
      d = '0;
      for (int j = 0; j < bpw; j++) begin
        k = i * bpw + j;
        b = (k < n) ? msg[k] : 8'($urandom);
        d = {d[55:0], b};
      end
      last = (i == nw - 1);
      nb   = last ? 3'(n % bpw) : 3'($urandom);
      put_word(w64, d, last, nb);
    end
  endtask

  // Standard SM3 padding of msg: 0x80, zeros to 56 mod 64, 64-bit BE length.
  task automatic model();
    logic [7:0]   p[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int nblk;
    bitlen = 64'(msg.size()) * 64'd8;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    nblk = p.size() / 64;
    e_d.delete(); e_l.delete();
    for (int bi = 0; bi < nblk; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi + j];
      e_d.push_back(blk);
      e_l.push_back(bi == nblk - 1);
    end
  endtask

  task automatic collect(input bit w64, input string name);
    logic [511:0] gd[$];
    bit           gl[$];
    int n;
    n = 0;
    while (((w64 ? q_d64.size() : q_d32.size()) < e_d.size()) && n < 2000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    if (w64) begin gd = q_d64; gl = q_l64; q_d64.delete(); q_l64.delete(); end
    else     begin gd = q_d32; gl = q_l32; q_d32.delete(); q_l32.delete(); end
    checks++;
    if (gd.size() !== e_d.size()) begin
      failures++;
      $display("FAIL %s block_count got %0d exp %0d", name, gd.size(), e_d.size());
    end
    for (int i = 0; i < e_d.size() && i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== e_d[i]) begin
        failures++;
        $display("FAIL %s blk%0d data got %h exp %h", name, i, gd[i], e_d[i]);
      end
      checks++;
      if (gl[i] !== e_l[i]) begin
        failures++;
        $display("FAIL %s blk%0d last got %0b exp %0b", name, i, gl[i], e_l[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ((w64 ? busy64 : busy32) !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after got 1 exp 0", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    e_d.delete(); e_l.delete();
    e_d.push_back(c_ABC); e_l.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    v32 = 0; l32 = 0; d32 = '0; b32 = '0; brdy32 = 1'b1;
    v64 = 0; l64 = 0; d64 = '0; b64 = '0; brdy64 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (r32 !== 1'b1)    begin failures++; $display("FAIL reset in_ready32 got %b exp 1", r32); end
    checks++; if (r64 !== 1'b1)    begin failures++; $display("FAIL reset in_ready64 got %b exp 1", r64); end
    checks++; if (bv32 !== 1'b0)   begin failures++; $display("FAIL reset blk_valid got %b exp 0", bv32); end
    checks++; if (bl32 !== 1'b0)   begin failures++; $display("FAIL reset blk_last got %b exp 0", bl32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset busy got %b exp 0", busy32); end
    checks++; if (bd32 !== '0)     begin failures++; $display("FAIL reset blk_data got %h exp 0", bd32); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    set_abc();
    send_msg(1'b0);
    collect(1'b0, "abc32");
  endtask

  task automatic test_full_block();
    msg.delete();
    for (int i = 0; i < 16; i++) begin
      msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63); msg.push_back(8'h64);
    end
    model();
    send_msg(1'b0);
    collect(1'b0, "abcd16");
  endtask

  task automatic test_56_bytes();
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    model();
    send_msg(1'b0);
    collect(1'b0, "len56");
  endtask

  task automatic test_backpressure();
    int n;
    brdy32 = 1'b0;
    set_abc();
    send_msg(1'b0);
    n = 0;
    while (bv32 !== 1'b1 && n < 20) begin tick(); n++; end
    v32 = 1'b1; d32 = 32'hDEADBEEF; l32 = 1'b1; b32 = 2'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bv32 !== 1'b1)   begin failures++; $display("FAIL stall%0d blk_valid got %b exp 1", c, bv32); end
      checks++; if (bd32 !== c_ABC)  begin failures++; $display("FAIL stall%0d blk_data got %h exp %h", c, bd32, c_ABC); end
      checks++; if (r32 !== 1'b0)    begin failures++; $display("FAIL stall%0d in_ready got %b exp 0", c, r32); end
      checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL stall%0d busy got %b exp 1", c, busy32); end
      @(posedge clk);
      #1;
    end
    v32 = 1'b0; l32 = 1'b0;
    brdy32 = 1'b1;
    collect(1'b0, "stall_release");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) put_word(1'b0, 64'($urandom), 1'b0, 3'd0);
    rst = 1'b0;
    #1;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL rst_mid busy got %b exp 0", busy32); end
    checks++; if (r32 !== 1'b1)    begin failures++; $display("FAIL rst_mid in_ready got %b exp 1", r32); end
    checks++; if (bd32 !== '0)     begin failures++; $display("FAIL rst_mid blk_data got %h exp 0", bd32); end
    @(posedge clk);
    #1 rst = 1'b1;
    set_abc();
    send_msg(1'b0);
    collect(1'b0, "abc_after_rst");
    // Reset while a block is waiting for the consumer.
    brdy32 = 1'b0;
    for (int i = 0; i < 16; i++) put_word(1'b0, 64'($urandom), 1'b0, 3'd0);
    tick();
    checks++; if (bv32 !== 1'b1) begin failures++; $display("FAIL emit_pending blk_valid got %b exp 1", bv32); end
    rst = 1'b0;
    #1;
    checks++; if (bv32 !== 1'b0) begin failures++; $display("FAIL rst_emit blk_valid got %b exp 0", bv32); end
    checks++; if (bd32 !== '0)   begin failures++; $display("FAIL rst_emit blk_data got %h exp 0", bd32); end
    @(posedge clk);
    #1 rst = 1'b1;
    brdy32 = 1'b1;
    e_d.delete(); e_l.delete();
    collect(1'b0, "no_block_after_rst");
  endtask

  task automatic test_w64_abc();
    set_abc();
    send_msg(1'b1);
    collect(1'b1, "abc64");
  endtask

  task automatic test_random();
    int lens[8] = '{55, 56, 57, 63, 64, 65, 119, 120};
    int len;
    rnd_rdy = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        msg.delete();
        for (int i = 0; i < lens[k]; i++) msg.push_back(8'($urandom));
        model();
        send_msg(w[0]);
        collect(w[0], w[0] ? "edge64" : "edge32");
      end
      for (int k = 0; k < 12; k++) begin
        len = $urandom_range(1, 140);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        model();
        send_msg(w[0]);
        collect(w[0], w[0] ? "rand64" : "rand32");
      end
    end
    rnd_rdy = 1'b0;
    brdy32 = 1'b1;
    brdy64 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_block();
    test_56_bytes();
    test_backpressure();
    test_reset_mid();
    test_w64_abc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm3_stream_padder.md
SM3_STREAM_PADDER -- requirements
Module: sm3_stream_padder

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning input word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter LEN_W, default 64, meaning message bit-length counter width; legal values are 1..64.
REQ-003 The block SHALL have port clk  input  1  clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  input word valid.
REQ-006 The block SHALL have port in_ready  output  1  block accepts an input word.
REQ-007 The block SHALL have port in_data  input  WORD_W  message word; the first byte is the MSB byte.
REQ-008 The block SHALL have port in_last  input  1  final word of the message.
REQ-009 The block SHALL have port in_bytes  input  clog2(WORD_W/8)  count of valid bytes on the last word; 0 means all bytes are valid.
REQ-010 The block SHALL have port blk_valid  output  1  padded block valid.
REQ-011 The block SHALL have port blk_ready  input  1  consumer accepts the block.
REQ-012 The block SHALL have port blk_data  output  512  padded block; the first message byte is at bits [511:504].
REQ-013 The block SHALL have port blk_last  output  1  final block of the message.
REQ-014 The block SHALL have port busy  output  1  a message is in progress or a block is pending.

Function
REQ-015 The FSM SHALL have the states FILL, EMIT, LENBLK and EMIT_LAST.
REQ-016 in_ready SHALL be 1 only in FILL; a word is accepted on in_valid & in_ready.
REQ-017 In FILL, each accepted word SHALL be written at word slot widx, big-endian, and widx SHALL increment.
REQ-018 On each accepted word, bit count SHALL add WORD_W, or 8*in_bytes when in_last is set and in_bytes != 0.
REQ-019 Bit count SHALL wrap modulo 2^LEN_W.
REQ-020 When a non-last word fills slot 512/WORD_W-1, the FSM SHALL go to EMIT with blk_last=0, and then return to FILL with the buffer cleared and widx=0.
REQ-021 On an accepted last word, byte 0x80 SHALL be placed directly after the last valid byte, and all following bytes in the block SHALL be zero.
REQ-022 If the message bytes plus the 0x80 byte occupy 56 bytes or fewer of the block, bits [63:0] SHALL carry the zero-extended bit count, and the FSM SHALL go to EMIT_LAST with blk_last=1.
REQ-023 If they occupy 57..64 bytes, the FSM SHALL go to EMIT with blk_last=0, then to LENBLK.
REQ-024 LENBLK SHALL form a block of zeros with bits [63:0] set to the bit count, then go to EMIT_LAST.
REQ-025 If the last word exactly fills the block, no 0x80 byte SHALL be placed in that block; the LENBLK block SHALL instead begin with 0x80 at bits [511:504].
REQ-026 blk_valid SHALL be 1 in EMIT and EMIT_LAST.
REQ-027 blk_data and blk_last SHALL stay stable while blk_valid & !blk_ready.
REQ-028 The FSM SHALL leave an EMIT state only on blk_ready.
REQ-029 After the EMIT_LAST handshake, the FSM SHALL go to FILL with the bit count zeroed, ready for the next message on the next cycle.
REQ-030 Latency SHALL be one cycle from the accepted word that completes a block to blk_valid=1.
REQ-031 busy SHALL be 1 from the first accepted word until the EMIT_LAST handshake.
REQ-032 in_bytes SHALL be ignored when in_last is 0.
REQ-033 A zero-length message is not supported.

Reset
REQ-034 On rst=0, the block SHALL asynchronously set state=FILL, widx=0, bit count=0, buffer=0, blk_data=0, blk_valid=0, blk_last=0 and busy=0.
REQ-035 in_ready SHALL be 1 on the first clock after reset release.
REQ-036 Reset asserted mid-message or mid-emit SHALL discard all partial state, and no block SHALL be emitted for that message.

Structure
REQ-037 Package sm3_pkg SHALL hold SM3_BLK_W=512, SM3_LEN_W=64, SM3_PAD_BYTE=8'h80 and the padder state enum.
REQ-038 Sub-module sm3_pad_mask SHALL be combinational and generate the byte keep-mask and the 0x80 insert position from widx and in_bytes.

Verification
REQ-039 The bench SHALL drive "abc" as one word 0x61626300 with in_bytes=3, last, and check one block: 0x61626380, then zeros, bits [63:0]=0x18, blk_last=1.
REQ-040 The bench SHALL drive 16 words of "abcd", the last marked last, and check two blocks: the message with blk_last=0, then 0x80000000..0 with length 0x200 and blk_last=1.
REQ-041 The bench SHALL drive a 56-byte message (14 words) and check two blocks: the first with 0x80 at byte 56 and zero length field, the second zeros with length 0x1C0.
REQ-042 The bench SHALL hold blk_ready=0 for 5 cycles and check that blk_data and blk_valid hold, in_ready=0, and no input is accepted.
REQ-043 The bench SHALL assert rst after 7 words of a message, then drive "abc", and check that the output equals the REQ-039 result with no stale data.
REQ-044 The bench SHALL set WORD_W=64 and drive "abc" as 0x6162630000000000 with in_bytes=3, and check a block identical to the REQ-039 result.
